thd_measure_seq: RTL and testbench
==================================

Name: thd_measure_seq

Overview:
- Top-level sequencer for one THD measurement.
- Fills the sample capture RAM from the ADC strobe, pulses the FFT engine, then holds start to the THD calculator until its done level, and latches results.
- Supports one-shot and free-running (continuous) modes, with a hold-off between runs and a watchdog on each downstream stage.
- Sits between the ADC front end, the FFT/magnitude RAM block, the THD calculator and the display/UART result path.

Parameters:
- N_POINTS, 4096, samples captured per measurement (power of 2, ≥4).
- ADDR_W, 12, capture address width; log2(N_POINTS).
- TIMEOUT_CYC, 1048575, maximum cycles allowed in FFT or THD state before abort (≥2).
- HOLDOFF_CYC, 50000, idle cycles between consecutive runs in continuous mode (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous and active-low.
- run  in  1  level; continuous measurement while high.
- single  in  1  one-cycle pulse; requests exactly one measurement.
- adc_valid  in  1  one-cycle strobe, new ADC sample present.
- cap_wr_en  out  1  capture RAM write enable; equals adc_valid while in CAPTURE.
- cap_addr  out  ADDR_W  capture RAM write address.
- fft_start  out  1  one-cycle pulse to the FFT engine.
- fft_done  in  1  one-cycle pulse; magnitude RAM complete.
- thd_start  out  1  level start to the THD calculator.
- thd_done  in  1  level done from the THD calculator.
- thd_in  in  16  THD ×100 from the calculator.
- fund_in  in  16  fundamental magnitude from the calculator.
- thd_result  out  16  latched THD.
- fund_result  out  16  latched fundamental.
- result_valid  out  1  one-cycle pulse; new result latched.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky abort flag.
- meas_count  out  16  count of completed measurements, wraps at 65535→0.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; every output 0; internal counters 0. Reset mid-run aborts immediately with no result pulse.
- States: IDLE, CAPTURE, FFT, THD, HOLDOFF.
- IDLE:
  - run=1 or single=1 → CAPTURE next cycle; cap_addr cleared to 0.
  - timeout_err clears on this entry.
  - A single pulse arriving while not in IDLE is ignored (not queued).
- CAPTURE:
  - cap_wr_en = adc_valid (combinational); cap_addr increments after each write.
  - The write at cap_addr = N_POINTS-1 completes capture: cap_addr wraps to 0, and the next cycle asserts fft_start for exactly 1 cycle and enters FFT.
  - adc_valid outside CAPTURE is ignored; cap_wr_en = 0.
- FFT:
  - Wait for fft_done. On fft_done: thd_start ← 1, state THD.
  - fft_done seen on the same cycle as fft_start is ignored.
- THD:
  - thd_start held high until thd_done=1 is sampled.
  - On that cycle, register thd_in→thd_result and fund_in→fund_result; result_valid=1 for 1 cycle; meas_count+1; thd_start←0.
  - Next state is HOLDOFF if run=1, else IDLE.
- HOLDOFF:
  - Counts HOLDOFF_CYC cycles, then enters CAPTURE if run=1.
  - If run=0 at any cycle in HOLDOFF, go to IDLE.
  - Waiting for thd_done to fall is not required; the calculator returns to idle on thd_start low.
- Watchdog:
  - A cycle counter clears on entering FFT and THD and increments each cycle in those states.
  - Reaching TIMEOUT_CYC forces IDLE: timeout_err←1, thd_start←0, no result_valid, results keep previous value.
- Dropping run mid-CAPTURE/FFT/THD does not abort; the current measurement completes, then IDLE.
- Results and meas_count change only on a successful completion.
- Latency, run rising to fft_start: N_POINTS adc_valid strobes + 2 cycles.

Test Plan:
- N_POINTS=8. Pulse single, adc_valid every 3rd cycle:
  - cap_addr writes 0..7 then wraps to 0.
  - fft_start high 1 cycle, exactly 2 cycles after the 8th write; busy=1 throughout.
- Then fft_done after 10 cycles; thd_done raised after 5 cycles with thd_in=0x012C, fund_in=0x3A00:
  - thd_result=0x012C, fund_result=0x3A00, result_valid 1 cycle, meas_count=1.
  - thd_start low the cycle after done; IDLE, busy=0.
- run=1, HOLDOFF_CYC=4, three runs:
  - meas_count=3.
  - Exactly 4 cycles in HOLDOFF between result_valid and the next CAPTURE entry.
  - run dropped during third THD → IDLE after its result.
- TIMEOUT_CYC=20, fft_done never asserted:
  - IDLE after 20 FFT cycles; timeout_err=1; thd_start never high; results unchanged.
  - Next single clears timeout_err.
- single pulsed during CAPTURE → ignored (meas_count advances by 1 only). adc_valid in IDLE → cap_wr_en stays 0.
- rst_n=0 for 1 cycle during THD → all outputs 0 next cycle including thd_result and meas_count; later thd_done=1 produces no result_valid.

Source files
------------

// File: rtl/thd_measure_seq.sv
// thd_measure_seq: sequences capture, FFT and THD calculation for one measurement, with continuous mode and watchdog
module thd_measure_seq #(
  parameter int N_POINTS    = 4096,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 1048575,
  parameter int HOLDOFF_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              single,
  input  logic              adc_valid,
  output logic              cap_wr_en,
  output logic [ADDR_W-1:0] cap_addr,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              thd_start,
  input  logic              thd_done,
  input  logic [15:0]       thd_in,
  input  logic [15:0]       fund_in,
  output logic [15:0]       thd_result,
  output logic [15:0]       fund_result,
  output logic              result_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       meas_count
);
  localparam int CMAX = TIMEOUT_CYC > HOLDOFF_CYC ? TIMEOUT_CYC : HOLDOFF_CYC;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, CAPTURE, FFT, THD, HOLDOFF} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic cap_done, wrap, wd_hit, ho_hit, fft_ok, abort;
  assign cap_wr_en = state == CAPTURE && adc_valid && !cap_done;
  assign busy = state != IDLE;
  assign wrap = cap_wr_en && cap_addr == ADDR_W'(N_POINTS - 1);
  assign wd_hit = cnt == CW'(TIMEOUT_CYC - 1);
  assign ho_hit = cnt == CW'(HOLDOFF_CYC - 1);
  assign fft_ok = state == FFT && fft_done && !fft_start;
  assign abort = wd_hit && ((state == FFT && !fft_ok) || (state == THD && !thd_done));
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (run || single) ? CAPTURE : IDLE;
      CAPTURE: state_nx = cap_done ? FFT : CAPTURE;
      FFT:     state_nx = fft_ok ? THD : abort ? IDLE : FFT;
      THD:     state_nx = thd_done ? (run ? HOLDOFF : IDLE) : abort ? IDLE : THD;
      HOLDOFF: state_nx = !run ? IDLE : ho_hit ? CAPTURE : HOLDOFF;
      default: state_nx = IDLE;
    endcase
  end
  // cnt is shared: watchdog in FFT/THD, hold-off timer in HOLDOFF; restarts on every state change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      cap_done     <= 1'b0;
      cap_addr     <= '0;
      fft_start    <= 1'b0;
      thd_start    <= 1'b0;
      thd_result   <= '0;
      fund_result  <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      meas_count   <= '0;
    end else begin
      cnt          <= state_nx != state ? '0 : cnt + 1'b1;
      cap_done     <= wrap;
      cap_addr     <= (state != CAPTURE && state_nx == CAPTURE) ? '0 : cap_wr_en ? cap_addr + 1'b1 : cap_addr;
      fft_start    <= state == CAPTURE && cap_done;
      thd_start    <= state_nx == THD;
      result_valid <= state == THD && thd_done;
      timeout_err  <= (state == IDLE && state_nx == CAPTURE) ? 1'b0 : abort ? 1'b1 : timeout_err;
      if (state == THD && thd_done) begin
        thd_result  <= thd_in;
        fund_result <= fund_in;
        meas_count  <= meas_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_thd_measure_seq.sv
// tb_thd_measure_seq: randomized scoreboard bench; driver predicts write/fft/result events, monitor checks them
module tb_thd_measure_seq;
  localparam int N = 8;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, single = 1'b0, adc_valid = 1'b0;
  logic fft_done = 1'b0, thd_done = 1'b0;
  logic [15:0] thd_in = '0, fund_in = '0;
  logic cap_wr_en, fft_start, thd_start, result_valid, busy, timeout_err;
  logic [2:0] cap_addr;
  logic [15:0] thd_result, fund_result, meas_count;
  thd_measure_seq #(.N_POINTS(N), .ADDR_W(3), .TIMEOUT_CYC(20), .HOLDOFF_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .single(single), .adc_valid(adc_valid),
    .cap_wr_en(cap_wr_en), .cap_addr(cap_addr), .fft_start(fft_start), .fft_done(fft_done),
    .thd_start(thd_start), .thd_done(thd_done), .thd_in(thd_in), .fund_in(fund_in),
    .thd_result(thd_result), .fund_result(fund_result), .result_valid(result_valid),
    .busy(busy), .timeout_err(timeout_err), .meas_count(meas_count)
  );
  always #5 clk = ~clk;
  typedef struct {int c; int a;} wr_t;
  typedef struct {int c; logic [15:0] t; logic [15:0] f; logic [15:0] n;} res_t;
  wr_t wq[$];
  int fq[$];
  res_t rq[$];
  int cyc = 0, vectors = 0, miscompares = 0;
  logic [15:0] exp_thd = '0, exp_fund = '0, exp_count = '0;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction
  function automatic void bad(string n);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event at cycle %0d", n, cyc);
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (cap_wr_en) begin
      if (wq.size() == 0) bad("wr_spurious");
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_cyc", cyc, e.c);
        chk("wr_addr", 32'(cap_addr), e.a);
      end
    end
    if (fft_start) begin
      if (fq.size() == 0) bad("fft_spurious");
      else chk("fft_cyc", cyc, fq.pop_front());
    end
    if (result_valid) begin
      if (rq.size() == 0) bad("res_spurious");
      else begin
        res_t r;
        r = rq.pop_front();
        chk("res_cyc", cyc, r.c);
        chk("thd_result", 32'(thd_result), 32'(r.t));
        chk("fund_result", 32'(fund_result), 32'(r.f));
        chk("meas_count", 32'(meas_count), 32'(r.n));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic at_neg();
    @(negedge clk);
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_wr"}, cap_wr_en, 0);
    chk({tag, "_addr"}, 32'(cap_addr), 0);
    chk({tag, "_fft"}, fft_start, 0);
    chk({tag, "_thd_start"}, thd_start, 0);
    chk({tag, "_thd"}, 32'(thd_result), 0);
    chk({tag, "_fund"}, 32'(fund_result), 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_to"}, timeout_err, 0);
    chk({tag, "_cnt"}, 32'(meas_count), 0);
  endtask
  // called in the first CAPTURE cycle (or first HOLDOFF cycle with pre=4); returns in the cycle after the last write
  task automatic capture(input int pre, input int gap, input bit dup);
    int last;
    last = 0;
    adc_valid = 1'b1;
    repeat (pre) tick();
    for (int i = 0; i < N; i++) begin
      adc_valid = 1'b0;
      repeat ($urandom_range(0, gap)) begin
        single = dup;
        tick();
        single = 1'b0;
      end
      adc_valid = 1'b1;
      wq.push_back('{cyc + 1, i});
      last = cyc + 1;
      tick();
    end
    adc_valid = 1'b0;
    fq.push_back(last + 2);
  endtask
  task automatic fft_thd(input int fd, input int td, input bit early, input bit drop,
                         input logic [15:0] tv, input logic [15:0] fv);
    tick();
    fft_done = early;
    tick();
    fft_done = 1'b0;
    repeat (fd - 1) tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    if (drop) run = 1'b0;
    repeat (td) begin
      at_neg();
      chk("thd_start_hi", thd_start, 1);
      tick();
    end
    thd_done = 1'b1;
    thd_in = tv;
    fund_in = fv;
    exp_thd = tv;
    exp_fund = fv;
    exp_count++;
    rq.push_back('{cyc + 2, tv, fv, exp_count});
    at_neg();
    chk("thd_start_done", thd_start, 1);
    tick();
    thd_done = 1'b0;
    thd_in = 16'($urandom);
    fund_in = 16'($urandom);
    at_neg();
    chk("thd_start_lo", thd_start, 0);
    chk("busy_after", busy, run);
  endtask
  task automatic rand_run(input bit drop);
    fft_thd($urandom_range(1, 15), $urandom_range(0, 12), 1'($urandom_range(0, 1)), drop,
            16'($urandom), 16'($urandom));
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    at_neg();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    adc_valid = 1'b1;
    at_neg();
    chk("idle_wr", cap_wr_en, 0);
    tick();
    adc_valid = 1'b0;
    single = 1'b1;
    tick();
    single = 1'b0;
    at_neg();
    chk("busy_cap", busy, 1);
    capture(0, 2, 1'b0);
    fft_thd(10, 5, 1'b1, 1'b0, 16'h012C, 16'h3A00);
    run = 1'b1;
    tick();
    capture(0, 2, 1'b0);
    rand_run(1'b0);
    capture(4, 0, 1'b0);
    rand_run(1'b0);
    capture(4, 0, 1'b0);
    rand_run(1'b1);
    tick();
    single = 1'b1;
    tick();
    single = 1'b0;
    capture(0, 1, 1'b0);
    tick();
    repeat (20) begin
      at_neg();
      chk("wd_busy", busy, 1);
      chk("wd_thd_start", thd_start, 0);
      tick();
    end
    at_neg();
    chk("wd_idle", busy, 0);
    chk("wd_err", timeout_err, 1);
    chk("wd_thd_keep", 32'(thd_result), 32'(exp_thd));
    chk("wd_fund_keep", 32'(fund_result), 32'(exp_fund));
    chk("wd_cnt_keep", 32'(meas_count), 32'(exp_count));
    single = 1'b1;
    tick();
    single = 1'b0;
    at_neg();
    chk("err_clear", timeout_err, 0);
    capture(0, 2, 1'b1);
    rand_run(1'b0);
    single = 1'b1;
    tick();
    single = 1'b0;
    capture(0, 0, 1'b0);
    tick();
    tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    at_neg();
    chk("rst_thd_start", thd_start, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    at_neg();
    chk_zero("midrst");
    exp_thd = '0;
    exp_fund = '0;
    exp_count = '0;
    thd_done = 1'b1;
    repeat (3) tick();
    thd_done = 1'b0;
    single = 1'b1;
    tick();
    single = 1'b0;
    capture(0, 2, 1'b0);
    rand_run(1'b0);
    repeat (3) tick();
    chk("wq_drained", wq.size(), 0);
    chk("fq_drained", fq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
